// File: rtl/prog_clock_counter.sv
// prog_clock_counter
//   Programmable tick counter used as a general timebase / event counter.
//   An enable-gated prescaler produces one tick every (prescale+1) enabled
//   cycles. Each tick steps the count up or down in one of three modes:
//   free-run (wraps at 0 / 2^WIDTH-1), modulo (wraps between 0 and limit)
//   or one-shot (stops at its terminal value and raises done).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset (overrides everything)
//   en         in   count enable; gates the prescaler
//   dir        in   0 = count up, 1 = count down
//   mode       in   00 free-run, 01 modulo, 10 one-shot, 11 behaves as 00
//   limit      in   modulo / one-shot terminal value
//   prescale   in   divide ratio minus one
//   load       in   synchronous load of load_val (beats a tick on the same edge)
//   load_val   in   value loaded into count
//   clear_ovf  in   clears the sticky overflow flag
//   count      out  current count (registered)
//   tc         out  one-cycle terminal-count pulse (registered)
//   ovf        out  sticky wrap flag (free-run / modulo only)
//   done       out  one-shot finished; count frozen until load or rst
//   running    out  en & ~done (combinational)
//
// Interface semantics: there is no handshake. All inputs are sampled on the
// rising edge; priority on each edge is rst > load > tick.

module prog_clock_counter #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  clear_ovf,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  done,
  output logic                  running
);

  localparam logic [1:0]       MODE_FREE    = 2'b00;
  localparam logic [1:0]       MODE_MODULO  = 2'b01;
  localparam logic [1:0]       MODE_ONESHOT = 2'b10;
  localparam logic [WIDTH-1:0] CNT_ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX      = '1;

  logic [PRESCALE_W-1:0] pre_q,   pre_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  tc_q,    tc_d;
  logic                  ovf_q,   ovf_d;
  logic                  done_q,  done_d;

  logic                  tick;
  logic [1:0]            mode_eff;
  logic [WIDTH-1:0]      cnt_inc;
  logic [WIDTH-1:0]      cnt_dec;
  logic [WIDTH-1:0]      cnt_step;
  logic [WIDTH-1:0]      terminal;

  // Register process: everything that holds state lives here.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Prescaler. The >= compare (rather than ==) means a prescale value that
  // drops below the current prescaler position still produces a tick on the
  // next enabled cycle instead of running all the way round.
  always_comb begin
    tick  = 1'b0;
    pre_d = pre_q;
    if (en) begin
      if (pre_q >= prescale) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    if (load) begin
      pre_d = '0;
    end
  end

  // Count, terminal-count, done and overflow next-state.
  always_comb begin
    mode_eff = (mode == 2'b11) ? MODE_FREE : mode;
    cnt_inc  = count_q + CNT_ONE;
    cnt_dec  = count_q - CNT_ONE;
    cnt_step = dir ? cnt_dec : cnt_inc;
    terminal = dir ? '0 : limit;

    count_d  = count_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    ovf_d    = ovf_q & ~clear_ovf;

    if (load) begin
      count_d = load_val;
      done_d  = 1'b0;
    end else if (tick) begin
      case (mode_eff)
        MODE_MODULO: begin
          if (!dir) begin
            // A load above limit wraps to 0 on the next up tick.
            if (count_q >= limit) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else begin
              count_d = cnt_inc;
            end
          end else begin
            if (count_q == '0) begin
              count_d = limit;
              tc_d    = 1'b1;
            end else begin
              count_d = cnt_dec;
            end
          end
        end
        MODE_ONESHOT: begin
          // Once done, ticks are ignored until a load or reset.
          if (!done_q) begin
            if (count_q == terminal) begin
              tc_d   = 1'b1;
              done_d = 1'b1;
            end else begin
              count_d = cnt_step;
              if (cnt_step == terminal) begin
                tc_d   = 1'b1;
                done_d = 1'b1;
              end
            end
          end
        end
        default: begin
          count_d = cnt_step;
          tc_d    = dir ? (count_q == '0) : (count_q == CNT_MAX);
        end
      endcase

      // Setting beats clearing when both land on the same edge.
      if (tc_d && (mode_eff != MODE_ONESHOT)) begin
        ovf_d = 1'b1;
      end
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign done    = done_q;
  assign running = en & ~done_q;

endmodule

// File: tb/tb_prog_clock_counter.sv
// Testbench for prog_clock_counter: a 16-bit instance driven by a table of
// per-cycle vectors, plus a 4-bit instance for the full free-run wrap.

module tb_prog_clock_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en = 1'b0, dir = 1'b0, load = 1'b0, clear_ovf = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] limit = '0, load_val = '0;
  logic [7:0]  prescale = '0;

  logic [15:0] count;
  logic        tc, ovf, done, running;
  logic [3:0]  count4;
  logic        tc4, ovf4, done4, running4;

  prog_clock_counter #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .limit(limit),
    .prescale(prescale), .load(load), .load_val(load_val), .clear_ovf(clear_ovf),
    .count(count), .tc(tc), .ovf(ovf), .done(done), .running(running)
  );

  prog_clock_counter #(.WIDTH(4), .PRESCALE_W(8)) dut4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .limit(limit[3:0]),
    .prescale(prescale), .load(load), .load_val(load_val[3:0]), .clear_ovf(clear_ovf),
    .count(count4), .tc(tc4), .ovf(ovf4), .done(done4), .running(running4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, en, dir;
    logic [1:0]  mode;
    logic [15:0] limit;
    logic [7:0]  prescale;
    logic        load;
    logic [15:0] load_val;
    logic        clr;
    logic [15:0] exp_count;
    logic        exp_tc, exp_ovf, exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic d, logic [1:0] m, logic [15:0] lim,
                              logic [7:0] p, logic ld, logic [15:0] lv, logic c,
                              logic [15:0] ec, logic et, logic eo, logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.mode = m; v.limit = lim; v.prescale = p;
    v.load = ld; v.load_val = lv; v.clr = c;
    v.exp_count = ec; v.exp_tc = et; v.exp_ovf = eo; v.exp_done = ed;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input vec_t v);
    rst = v.rst; en = v.en; dir = v.dir; mode = v.mode; limit = v.limit;
    prescale = v.prescale; load = v.load; load_val = v.load_val; clear_ovf = v.clr;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: two cycles, then check reset state of both instances.
    step();
    step();
    check("reset_count", count, 16'h0);
    check("reset_tc", tc, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_count4", count4, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    // 4-bit free-run up, prescale 0: 1..15 then 0 on the 16th edge.
    for (int k = 1; k <= 16; k++) exp_q.push_back(16'(k % 16));
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic [15:0] e;
      step();
      e = exp_q.pop_front();
      check($sformatf("w4_count[%0d]", k), count4, e[3:0]);
      check($sformatf("w4_tc[%0d]", k), tc4, (k == 16));
      if (k >= 15) check($sformatf("w4_ovf[%0d]", k), ovf4, (k == 16));
      if (k == 1) check("w4_running", running4, 1'b1);
      @(negedge clk);
    end
    en = 1'b0;

    // Table: rst en dir mode limit pre ld lv clr | count tc ovf done
    // Reset in the middle of a count.
    vecs.push_back(mk(0,0,0,2'b00,16'd0,8'd0,1,16'h1234,0, 16'h1234,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd0,0,16'h0,0,    16'h1235,0,0,0));
    vecs.push_back(mk(1,1,0,2'b00,16'd0,8'd0,0,16'h0,0,    16'h0,0,0,0));
    vecs.push_back(mk(1,1,0,2'b00,16'd0,8'd0,0,16'h0,0,    16'h0,0,0,0));
    // Modulo up, limit 9, prescale 2; en=0 freezes count and prescaler.
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,1,16'd7,0, 16'd7,0,0,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd7,0,0,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd7,0,0,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd8,0,0,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd8,0,0,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd8,0,0,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd9,0,0,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd9,0,0,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd9,0,0,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd0,1,1,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd0,0,1,0));
    vecs.push_back(mk(0,0,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd0,0,1,0));
    vecs.push_back(mk(0,0,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd0,0,1,0));
    vecs.push_back(mk(0,0,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd0,0,1,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd0,0,1,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd9,8'd2,0,16'd0,0, 16'd1,0,1,0));
    // Modulo down, limit 3; clear_ovf coinciding with a wrap loses to the set.
    vecs.push_back(mk(0,1,1,2'b01,16'd3,8'd0,1,16'd1,1, 16'd1,0,0,0));
    vecs.push_back(mk(0,1,1,2'b01,16'd3,8'd0,0,16'd0,0, 16'd0,0,0,0));
    vecs.push_back(mk(0,1,1,2'b01,16'd3,8'd0,0,16'd0,1, 16'd3,1,1,0));
    vecs.push_back(mk(0,1,1,2'b01,16'd3,8'd0,0,16'd0,0, 16'd2,0,1,0));
    vecs.push_back(mk(0,1,1,2'b01,16'd3,8'd0,0,16'd0,1, 16'd1,0,0,0));
    // One-shot down from 5: done and tc at 0, then frozen; no ovf.
    vecs.push_back(mk(0,1,1,2'b10,16'd3,8'd0,1,16'd5,0, 16'd5,0,0,0));
    vecs.push_back(mk(0,1,1,2'b10,16'd3,8'd0,0,16'd0,0, 16'd4,0,0,0));
    vecs.push_back(mk(0,1,1,2'b10,16'd3,8'd0,0,16'd0,0, 16'd3,0,0,0));
    vecs.push_back(mk(0,1,1,2'b10,16'd3,8'd0,0,16'd0,0, 16'd2,0,0,0));
    vecs.push_back(mk(0,1,1,2'b10,16'd3,8'd0,0,16'd0,0, 16'd1,0,0,0));
    vecs.push_back(mk(0,1,1,2'b10,16'd3,8'd0,0,16'd0,0, 16'd0,1,0,1));
    vecs.push_back(mk(0,1,1,2'b10,16'd3,8'd0,0,16'd0,0, 16'd0,0,0,1));
    vecs.push_back(mk(0,1,1,2'b10,16'd3,8'd0,0,16'd0,0, 16'd0,0,0,1));
    // One-shot up entered already at terminal.
    vecs.push_back(mk(0,1,0,2'b10,16'd6,8'd0,1,16'd6,0, 16'd6,0,0,0));
    vecs.push_back(mk(0,1,0,2'b10,16'd6,8'd0,0,16'd0,0, 16'd6,1,0,1));
    vecs.push_back(mk(0,1,0,2'b10,16'd6,8'd0,0,16'd0,0, 16'd6,0,0,1));
    // One-shot up, 4 -> 6.
    vecs.push_back(mk(0,1,0,2'b10,16'd6,8'd0,1,16'd4,0, 16'd4,0,0,0));
    vecs.push_back(mk(0,1,0,2'b10,16'd6,8'd0,0,16'd0,0, 16'd5,0,0,0));
    vecs.push_back(mk(0,1,0,2'b10,16'd6,8'd0,0,16'd0,0, 16'd6,1,0,1));
    vecs.push_back(mk(0,1,0,2'b10,16'd6,8'd0,0,16'd0,0, 16'd6,0,0,1));
    // Load beats a tick on the same edge, and restarts the prescaler.
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,1,16'h20,0, 16'h20,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,0,16'h0,0,  16'h20,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,0,16'h0,0,  16'h20,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,1,16'h0A,0, 16'h0A,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,0,16'h0,0,  16'h0A,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,0,16'h0,0,  16'h0A,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,0,16'h0,0,  16'h0B,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,0,16'h0,0,  16'h0B,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,1,16'h30,0, 16'h30,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,0,16'h0,0,  16'h30,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,0,16'h0,0,  16'h30,0,0,0));
    vecs.push_back(mk(0,1,0,2'b00,16'd0,8'd2,0,16'h0,0,  16'h31,0,0,0));
    // Mode 11 behaves as free-run: down wrap 0 -> FFFF.
    vecs.push_back(mk(0,1,1,2'b11,16'd0,8'd0,1,16'h0,0, 16'h0,0,0,0));
    vecs.push_back(mk(0,1,1,2'b11,16'd0,8'd0,0,16'h0,0, 16'hFFFF,1,1,0));
    vecs.push_back(mk(0,1,1,2'b11,16'd0,8'd0,0,16'h0,0, 16'hFFFE,0,1,0));
    // Modulo with limit 0, loaded above limit: wraps to 0, then tc every tick.
    vecs.push_back(mk(0,1,0,2'b01,16'd0,8'd0,1,16'd5,1, 16'd5,0,0,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd0,8'd0,0,16'd0,0, 16'd0,1,1,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd0,8'd0,0,16'd0,0, 16'd0,1,1,0));
    vecs.push_back(mk(0,1,0,2'b01,16'd0,8'd0,0,16'd0,0, 16'd0,1,1,0));
    // Modulo down loaded above limit decrements normally.
    vecs.push_back(mk(0,1,1,2'b01,16'd3,8'd0,1,16'd9,0, 16'd9,0,1,0));
    vecs.push_back(mk(0,1,1,2'b01,16'd3,8'd0,0,16'd0,0, 16'd8,0,1,0));

    foreach (vecs[i]) begin
      logic [15:0] e;
      drive_vec(vecs[i]);
      exp_q.push_back(vecs[i].exp_count);
      step();
      e = exp_q.pop_front();
      check($sformatf("vec[%0d].count", i), count, e);
      check($sformatf("vec[%0d].tc", i), tc, vecs[i].exp_tc);
      check($sformatf("vec[%0d].ovf", i), ovf, vecs[i].exp_ovf);
      check($sformatf("vec[%0d].done", i), done, vecs[i].exp_done);
      check($sformatf("vec[%0d].running", i), running, vecs[i].en & ~vecs[i].exp_done);
      @(negedge clk);
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
